// File: rtl/vc_demux_rx_if.sv
// Bundle of the receive-side serial bit stream and the consumer read port of vc_demux_rx.
// The master drives the link and read requests; the slave is the demultiplexer.
interface vc_demux_rx_if #(
   parameter int WORD_W = 4
);
   logic              valid_in;
   logic              data_in;
   logic [1:0]        VC_id;
   logic              rd_en;
   logic [1:0]        rd_vc;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic [3:0]        empty;
   logic [3:0]        full;
   logic [3:0]        overflow;

   modport master (
      output valid_in, data_in, VC_id, rd_en, rd_vc,
      input  word_out, word_valid, empty, full, overflow
   );

   modport slave (
      input  valid_in, data_in, VC_id, rd_en, rd_vc,
      output word_out, word_valid, empty, full, overflow
   );
endinterface

// File: rtl/vc_demux_rx.sv
// Receive end of the 4-VC serial link.
// Bits are reassembled MSB-first per VC and queued in per-VC FIFOs drained through a select/read port.
module vc_demux_rx #(
   parameter int WORD_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   vc_demux_rx_if.slave bus
);
   localparam int BCW = $clog2(WORD_W);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   logic [WORD_W-1:0] sr_r   [4];
   logic [BCW-1:0]    bc_r   [4];
   logic [WORD_W-1:0] mem_r  [4][FIFO_DEPTH];
   logic [PW-1:0]     wp_r   [4];
   logic [PW-1:0]     rp_r   [4];
   logic [CW-1:0]     cnt_r  [4];
   logic [CW-1:0]     cnt_nxt_s [4];
   logic [WORD_W-1:0] word_s [4];
   logic [3:0]        hit_s;
   logic [3:0]        push_s;
   logic [3:0]        pop_s;
   logic [3:0]        accept_s;
   logic [3:0]        empty_r;
   logic [3:0]        full_r;
   logic [3:0]        overflow_r;
   logic [WORD_W-1:0] head_s;
   logic [WORD_W-1:0] word_out_r;
   logic              word_valid_r;

   // Per-VC push/pop decisions and next occupancy
   always_comb begin
      hit_s    = 4'b0000;
      push_s   = 4'b0000;
      pop_s    = 4'b0000;
      accept_s = 4'b0000;
      for (int v = 0; v < 4; v++) begin
         word_s[v]    = {sr_r[v][WORD_W-2:0], bus.data_in};
         hit_s[v]     = bus.valid_in && (bus.VC_id == 2'(v));
         push_s[v]    = hit_s[v] && (bc_r[v] == BCW'(WORD_W - 1));
         // Pop is qualified by the registered empty flag, so an empty FIFO never bypasses.
         pop_s[v]     = bus.rd_en && (bus.rd_vc == 2'(v)) && !empty_r[v];
         accept_s[v]  = push_s[v] && (!full_r[v] || pop_s[v]);
         if (accept_s[v] && !pop_s[v]) begin
            cnt_nxt_s[v] = cnt_r[v] + CW'(1);
         end else if (pop_s[v] && !accept_s[v]) begin
            cnt_nxt_s[v] = cnt_r[v] - CW'(1);
         end else begin
            cnt_nxt_s[v] = cnt_r[v];
         end
      end
      head_s = mem_r[bus.rd_vc][rp_r[bus.rd_vc]];
   end

   // Deserialisers, FIFO pointers, flags and registered read port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int v = 0; v < 4; v++) begin
            sr_r[v]  <= {WORD_W{1'b0}};
            bc_r[v]  <= {BCW{1'b0}};
            wp_r[v]  <= {PW{1'b0}};
            rp_r[v]  <= {PW{1'b0}};
            cnt_r[v] <= {CW{1'b0}};
         end
         empty_r      <= 4'b1111;
         full_r       <= 4'b0000;
         overflow_r   <= 4'b0000;
         word_out_r   <= {WORD_W{1'b0}};
         word_valid_r <= 1'b0;
      end else begin
         for (int v = 0; v < 4; v++) begin
            if (hit_s[v]) begin
               sr_r[v] <= word_s[v];
               bc_r[v] <= push_s[v] ? {BCW{1'b0}} : bc_r[v] + BCW'(1);
            end
            if (accept_s[v]) begin
               wp_r[v] <= wp_r[v] + PW'(1);
            end
            if (pop_s[v]) begin
               rp_r[v] <= rp_r[v] + PW'(1);
            end
            if (push_s[v] && !accept_s[v]) begin
               overflow_r[v] <= 1'b1;
            end
            cnt_r[v]   <= cnt_nxt_s[v];
            empty_r[v] <= (cnt_nxt_s[v] == CW'(0));
            full_r[v]  <= (cnt_nxt_s[v] == CW'(FIFO_DEPTH));
         end
         if (|pop_s) begin
            word_out_r <= head_s;
         end
         word_valid_r <= |pop_s;
      end
   end

   // FIFO storage; the head is read before a same-edge write to a full FIFO lands
   always_ff @(posedge clk) begin
      for (int v = 0; v < 4; v++) begin
         if (accept_s[v]) begin
            mem_r[v][wp_r[v]] <= word_s[v];
         end
      end
   end

   assign bus.word_out   = word_out_r;
   assign bus.word_valid = word_valid_r;
   assign bus.empty      = empty_r;
   assign bus.full       = full_r;
   assign bus.overflow   = overflow_r;
endmodule
